// File: rtl/decompress_sequencer.sv
// Run-length decompression sequencer: expands (in1, in2) pairs from a shared byte RAM into a bit-packed region.
// Optional: define DCMP_ZERO_EOS_EN to treat a zero-length pair as an end-of-stream marker.
module decompress_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int PAIRS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [PAIRS_W-1:0] src_pairs,
  input  logic [ADDR_W-1:0] dst_byte_idx,
  input  logic [2:0]        dst_bit_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] new_byte_idx,
  output logic [2:0]        new_bit_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  typedef enum logic [3:0] {
    IDLE, HEAD_RD, HEAD_CAP, FETCH_HI, FETCH_LO, LOAD, FILL, NEXT, TAIL_RD, TAIL_WR, DONE
  } state_t;

  state_t             state, stateNext;
  logic [ADDR_W-1:0]  srcPtr, srcPtrNext, byteIdx, byteIdxNext, newByteReg;
  logic [PAIRS_W-1:0] pairsLeft, pairsLeftNext;
  logic [2:0]         bitIdx, bitIdxNext, newBitReg;
  logic [7:0]         acc, accNext, hiByte, hiByteNext;
  logic               runVal, runValNext, errNext;
  logic [14:0]        runLen, runLenNext;

  logic [3:0]  bitPlus1, fillN, remain;
  logic [8:0]  upToBit, belowFill;
  logic [7:0]  fillMask, accFilled;
  logic [14:0] loadLen;

  // Bits bit..bit-n+1 of the accumulator take the run value this cycle.
  always_comb begin
    bitPlus1  = {1'b0, bitIdx} + 4'd1;
    fillN     = (runLen < {11'd0, bitPlus1}) ? runLen[3:0] : bitPlus1;
    remain    = bitPlus1 - fillN;
    upToBit   = (9'd1 << bitPlus1) - 9'd1;
    belowFill = (9'd1 << remain) - 9'd1;
    fillMask  = upToBit[7:0] & ~belowFill[7:0];
    accFilled = runVal ? (acc | fillMask) : (acc & ~fillMask);
    loadLen   = {hiByte[6:0], mem_rdata};
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    stateNext     = state;
    srcPtrNext    = srcPtr;
    pairsLeftNext = pairsLeft;
    byteIdxNext   = byteIdx;
    bitIdxNext    = bitIdx;
    accNext       = acc;
    hiByteNext    = hiByte;
    runValNext    = runVal;
    runLenNext    = runLen;
    errNext       = err;
    mem_addr      = '0;
    mem_re        = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = 8'h00;

    unique case (state)
      IDLE: begin
        if (start) begin
          srcPtrNext    = src_addr;
          pairsLeftNext = src_pairs;
          byteIdxNext   = dst_byte_idx;
          bitIdxNext    = dst_bit_idx;
          accNext       = 8'h00;
          errNext       = 1'b0;
          if (src_pairs == '0)         stateNext = DONE;
          else if (dst_bit_idx != 3'd7) stateNext = HEAD_RD;
          else                          stateNext = FETCH_HI;
        end
      end
      HEAD_RD: begin
        mem_re    = 1'b1;
        mem_addr  = byteIdx;
        stateNext = HEAD_CAP;
      end
      HEAD_CAP: begin
        accNext   = mem_rdata & ~upToBit[7:0];
        stateNext = FETCH_HI;
      end
      FETCH_HI: begin
        mem_re    = 1'b1;
        mem_addr  = srcPtr;
        stateNext = FETCH_LO;
      end
      FETCH_LO: begin
        hiByteNext = mem_rdata;
        mem_re     = 1'b1;
        mem_addr   = srcPtr + ADDR_W'(1);
        stateNext  = LOAD;
      end
      LOAD: begin
        runValNext = hiByte[7];
        runLenNext = loadLen;
        if (loadLen != 15'd0) begin
          stateNext = FILL;
        end else begin
`ifdef DCMP_ZERO_EOS_EN
          stateNext = (bitIdx != 3'd7) ? TAIL_RD : DONE;
`else
          stateNext = NEXT;
`endif
        end
      end
      FILL: begin
        runLenNext = runLen - {11'd0, fillN};
        if (remain == 4'd0) begin
          mem_we     = 1'b1;
          mem_addr   = byteIdx;
          mem_wdata  = accFilled;
          accNext    = 8'h00;
          bitIdxNext = 3'd7;
          if (&byteIdx) begin
            // The cursor cannot advance past the top of RAM: flag it and skip the tail.
            errNext   = 1'b1;
            stateNext = DONE;
          end else begin
            byteIdxNext = byteIdx + ADDR_W'(1);
            if (runLen == {11'd0, fillN}) stateNext = NEXT;
          end
        end else begin
          accNext    = accFilled;
          bitIdxNext = 3'(remain - 4'd1);
          stateNext  = NEXT;
        end
      end
      NEXT: begin
        pairsLeftNext = pairsLeft - PAIRS_W'(1);
        if (pairsLeft != PAIRS_W'(1)) begin
          srcPtrNext = srcPtr + ADDR_W'(2);
          stateNext  = FETCH_HI;
        end else begin
          stateNext = (bitIdx != 3'd7) ? TAIL_RD : DONE;
        end
      end
      TAIL_RD: begin
        mem_re    = 1'b1;
        mem_addr  = byteIdx;
        stateNext = TAIL_WR;
      end
      TAIL_WR: begin
        mem_we    = 1'b1;
        mem_addr  = byteIdx;
        mem_wdata = acc | (mem_rdata & upToBit[7:0]);
        stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      srcPtr     <= '0;
      pairsLeft  <= '0;
      byteIdx    <= '0;
      bitIdx     <= 3'd7;
      acc        <= 8'h00;
      hiByte     <= 8'h00;
      runVal     <= 1'b0;
      runLen     <= '0;
      err        <= 1'b0;
      newByteReg <= '0;
      newBitReg  <= 3'd7;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state     <= stateNext;
      srcPtr    <= srcPtrNext;
      pairsLeft <= pairsLeftNext;
      byteIdx   <= byteIdxNext;
      bitIdx    <= bitIdxNext;
      acc       <= accNext;
      hiByte    <= hiByteNext;
      runVal    <= runValNext;
      runLen    <= runLenNext;
      err       <= errNext;
      if (state == DONE) begin
        newByteReg <= byteIdx;
        newBitReg  <= bitIdx;
      end
    end
  end

  // The final cursor is shown live during the done cycle and held afterwards.
  assign busy         = (state != IDLE) && (state != DONE);
  assign done         = (state == DONE);
  assign new_byte_idx = done ? byteIdx : newByteReg;
  assign new_bit_idx  = done ? bitIdx : newBitReg;

endmodule

// File: tb/tb_decompress_sequencer.sv
// Self-checking bench for decompress_sequencer: directed cases plus randomized jobs against a bit-level model.
module tb_decompress_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] src_addr, dst_byte_idx, src_pairs;
  logic [2:0]  dst_bit_idx;
  logic        busy, done, err;
  logic [15:0] new_byte_idx, mem_addr;
  logic [2:0]  new_bit_idx;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata, mem_wdata;

  bit [7:0] mem    [0:65535];
  bit [7:0] refMem [0:65535];
  logic        pokeEn;
  logic [15:0] pokeAddr;
  logic [7:0]  pokeData;
  int rdCount = 0, wrCount = 0, bothCount = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  decompress_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .src_pairs(src_pairs),
    .dst_byte_idx(dst_byte_idx), .dst_bit_idx(dst_bit_idx),
    .busy(busy), .done(done), .err(err),
    .new_byte_idx(new_byte_idx), .new_bit_idx(new_bit_idx),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  // Single-port RAM with a backdoor write path used only while the DUT is idle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pokeEn) mem[pokeAddr] <= pokeData;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_re) rdCount <= rdCount + 1;
    if (mem_we) wrCount <= wrCount + 1;
    if (mem_re && mem_we) bothCount <= bothCount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    refMem[a] = d;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  // Bit-stream model: the cursor is an absolute bit position counted MSB-first from byte 0.
  task automatic refRun(input logic [15:0] src, input logic [15:0] pairs, input logic [15:0] dB,
                        input logic [2:0] db, output logic [15:0] eB, output logic [2:0] eb,
                        output logic eErr);
    int p, len;
    bit v;
    logic [15:0] a;
    p = int'(dB) * 8 + (7 - int'(db));
    eErr = 1'b0;
    for (int k = 0; k < int'(pairs) && !eErr; k++) begin
      a   = 16'(int'(src) + 2 * k);
      v   = refMem[a][7];
      len = int'(refMem[a][6:0]) * 256 + int'(refMem[16'(a + 16'd1)]);
`ifdef DCMP_ZERO_EOS_EN
      if (len == 0) break;
`endif
      for (int j = 0; j < len; j++) begin
        refMem[16'(p / 8)][7 - (p % 8)] = v;
        p++;
        if (p == 65536 * 8) begin
          eErr = 1'b1;
          break;
        end
      end
    end
    if (eErr) begin
      eB = 16'hFFFF; eb = 3'd7;
    end else begin
      eB = 16'(p / 8); eb = 3'(7 - (p % 8));
    end
  endtask

  task automatic runJob(input logic [15:0] src, input logic [15:0] pairs, input logic [15:0] dB,
                        input logic [2:0] db, output logic [15:0] oB, output logic [2:0] oBit,
                        output logic oErr, output int rd, output int wr);
    int n, rd0, wr0;
    rd0 = rdCount; wr0 = wrCount;
    src_addr = src; src_pairs = pairs; dst_byte_idx = dB; dst_bit_idx = db; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(pairs != 16'd0));
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    oB = new_byte_idx; oBit = new_bit_idx; oErr = err;
    rd = rdCount - rd0; wr = wrCount - wr0;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_newbyte"}, 32'(new_byte_idx), 32'd0);
    check({tag, "_newbit"}, 32'(new_bit_idx), 32'd7);
    check({tag, "_re"}, 32'(mem_re), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    logic [15:0] gB, eB, src, dst, pairs;
    logic [2:0]  gb, eb, dbit;
    logic        gErr, eErr;
    int          rd, wr, len;
    logic [7:0]  hi, lo;

    rst = 1'b1; start = 1'b0; pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;
    src_addr = '0; src_pairs = '0; dst_byte_idx = '0; dst_bit_idx = '0;
    @(posedge clk); @(posedge clk); #1;
    checkResetValues("por");
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_re", 32'(mem_re), 32'd0);
    check("post_rst_we", 32'(mem_we), 32'd0);

    // Aligned run of 12 ones crossing a byte boundary.
    poke(16'h0011, 8'h05); poke(16'h0100, 8'h80); poke(16'h0101, 8'h0C);
    runJob(16'h0100, 16'd1, 16'h0010, 3'd7, gB, gb, gErr, rd, wr);
    check("t1_mem10", 32'(mem[16'h0010]), 32'hFF);
    check("t1_mem11", 32'(mem[16'h0011]), 32'hF5);
    check("t1_byte", 32'(gB), 32'h11);
    check("t1_bit", 32'(gb), 32'd3);
    check("t1_reads", 32'(rd), 32'd3);
    check("t1_writes", 32'(wr), 32'd2);
    check("t1_err", 32'(gErr), 32'd0);

    // Mid-byte head that completes its byte.
    poke(16'h0020, 8'hA5); poke(16'h0102, 8'h00); poke(16'h0103, 8'h04);
    runJob(16'h0102, 16'd1, 16'h0020, 3'd3, gB, gb, gErr, rd, wr);
    check("t2_mem20", 32'(mem[16'h0020]), 32'hA0);
    check("t2_byte", 32'(gB), 32'h21);
    check("t2_bit", 32'(gb), 32'd7);
    check("t2_reads", 32'(rd), 32'd3);
    check("t2_writes", 32'(wr), 32'd1);

    // Head and tail in the same byte.
    poke(16'h0030, 8'hFF); poke(16'h0104, 8'h00); poke(16'h0105, 8'h02);
    runJob(16'h0104, 16'd1, 16'h0030, 3'd5, gB, gb, gErr, rd, wr);
    check("t3_mem30", 32'(mem[16'h0030]), 32'hCF);
    check("t3_byte", 32'(gB), 32'h30);
    check("t3_bit", 32'(gb), 32'd3);
    check("t3_reads", 32'(rd), 32'd4);
    check("t3_writes", 32'(wr), 32'd1);

    // Three pairs with a zero-length pair in the middle.
    poke(16'h0040, 8'h00);
    poke(16'h0110, 8'h80); poke(16'h0111, 8'h03); poke(16'h0112, 8'h00);
    poke(16'h0113, 8'h00); poke(16'h0114, 8'h00); poke(16'h0115, 8'h05);
    runJob(16'h0110, 16'd3, 16'h0040, 3'd7, gB, gb, gErr, rd, wr);
    check("t4_mem40", 32'(mem[16'h0040]), 32'hE0);
`ifdef DCMP_ZERO_EOS_EN
    check("t4_byte", 32'(gB), 32'h40);
    check("t4_bit", 32'(gb), 32'd4);
    check("t4_reads", 32'(rd), 32'd5);
`else
    check("t4_byte", 32'(gB), 32'h41);
    check("t4_bit", 32'(gb), 32'd7);
    check("t4_reads", 32'(rd), 32'd6);
`endif
    check("t4_writes", 32'(wr), 32'd1);

    // Zero pairs: immediate done, no RAM traffic, cursor echoed back.
    runJob(16'h0200, 16'd0, 16'h0055, 3'd2, gB, gb, gErr, rd, wr);
    check("t5_byte", 32'(gB), 32'h55);
    check("t5_bit", 32'(gb), 32'd2);
    check("t5_access", 32'(rd + wr), 32'd0);

    // Overflow at the top of RAM.
    poke(16'hFFFF, 8'h00); poke(16'h0000, 8'h5A); poke(16'h0120, 8'h80); poke(16'h0121, 8'h09);
    runJob(16'h0120, 16'd1, 16'hFFFF, 3'd7, gB, gb, gErr, rd, wr);
    check("ovf_memFFFF", 32'(mem[16'hFFFF]), 32'hFF);
    check("ovf_mem0000", 32'(mem[16'h0000]), 32'h5A);
    check("ovf_err", 32'(gErr), 32'd1);
    check("ovf_byte", 32'(gB), 32'hFFFF);
    check("ovf_bit", 32'(gb), 32'd7);
    check("ovf_reads", 32'(rd), 32'd2);
    check("ovf_writes", 32'(wr), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_err_sticky", 32'(err), 32'd1);

    // Long job: start clears err, then an async reset lands mid-FILL.
    poke(16'h0130, 8'h80); poke(16'h0131, 8'hC8);
    src_addr = 16'h0130; src_pairs = 16'd1; dst_byte_idx = 16'h5000; dst_bit_idx = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_clears_err", 32'(err), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midfill_busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    checkResetValues("midjob_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_re", 32'(mem_re), 32'd0);
    check("rel_we", 32'(mem_we), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    // Overflow again, then reset must clear the sticky flag.
    runJob(16'h0120, 16'd1, 16'hFFFF, 3'd7, gB, gb, gErr, rd, wr);
    check("ovf2_err", 32'(gErr), 32'd1);
    #2 rst = 1'b1;
    #2;
    check("rst_clears_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized jobs in disjoint source/destination regions.
    for (int i = 0; i < 30; i++) begin
      src   = 16'(16'h1000 + i * 32);
      dst   = 16'(16'h2000 + i * 64);
      pairs = 16'($urandom_range(1, 5));
      dbit  = 3'($urandom_range(0, 7));
      for (int a = -1; a < 17; a++) poke(16'(int'(dst) + a), 8'($urandom_range(0, 255)));
      for (int k = 0; k < int'(pairs); k++) begin
        len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
        hi  = {1'($urandom_range(0, 1)), 7'(len / 256)};
        lo  = 8'(len % 256);
        poke(16'(int'(src) + 2 * k), hi);
        poke(16'(int'(src) + 2 * k + 1), lo);
      end
      refRun(src, pairs, dst, dbit, eB, eb, eErr);
      runJob(src, pairs, dst, dbit, gB, gb, gErr, rd, wr);
      check($sformatf("rand%0d_byte", i), 32'(gB), 32'(eB));
      check($sformatf("rand%0d_bit", i), 32'(gb), 32'(eb));
      check($sformatf("rand%0d_err", i), 32'(gErr), 32'(eErr));
      for (int a = -1; a < 17; a++)
        check($sformatf("rand%0d_mem%0h", i, 16'(int'(dst) + a)),
              32'(mem[16'(int'(dst) + a)]), 32'(refMem[16'(int'(dst) + a)]));
    end

    check("re_we_exclusive", 32'(bothCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
